// File: rtl/regfile_resp.sv
// Register file for decode: two same-cycle read ports, one write-back port,
// forwarding of the in-flight write, and a post-reset clear sequencer.
module regfile_resp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic              init_busy,
    output logic              wr_dropped
);

    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] regs [NREGS];

    assign init_busy = rst || (state == CLEAR);

    // Control path: reset restarts the clear walk from register 0 every time.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            wr_dropped <= 1'b0;
        end else begin
            wr_dropped <= we && (state == CLEAR);
            if (state == CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
                if (clr_cnt == LAST_IDX) begin
                    state <= RUN;
                end
            end
        end
    end

    // Storage carries no reset; the clear sequencer is what zeroes it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                regs[clr_cnt] <= '0;
            end else if (we && (waddr != '0)) begin
                regs[waddr] <= wdata;
            end
        end
    end

    function automatic logic [DATA_W-1:0] read_port(
        input logic              re,
        input logic [ADDR_W-1:0] raddr
    );
        logic [DATA_W-1:0] data;
        data = '0;
        if (init_busy || !re || (raddr == '0)) begin
            data = '0;
        end else if (we && (waddr == raddr)) begin
            data = wdata;
        end else begin
            data = regs[raddr];
        end
        return data;
    endfunction

    always_comb begin
        rdata1 = read_port(re1, raddr1);
        rdata2 = read_port(re2, raddr2);
    end

endmodule

// File: tb/tb_regfile_resp.sv
// Directed bench for regfile_resp: reset/clear timing, writes, forwarding,
// register 0, read enables, dropped writes and mid-run reset.
module tb_regfile_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic        init_busy;
    logic        wr_dropped;

    int checks = 0;
    int errors = 0;

    regfile_resp dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .re1       (re1),
        .raddr1    (raddr1),
        .rdata1    (rdata1),
        .re2       (re2),
        .raddr2    (raddr2),
        .rdata2    (rdata2),
        .init_busy (init_busy),
        .wr_dropped(wr_dropped)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b0; raddr2 = '0;

        // Reset held for two edges.
        tick();
        tick();
        settle();
        chk("rst_busy", 32'(init_busy), 32'd1);
        chk("rst_rdata1", rdata1, 32'd0);
        chk("rst_rdata2", rdata2, 32'd0);
        chk("rst_dropped", 32'(wr_dropped), 32'd0);

        // Release; clear runs 32 cycles, with a write attempted in cycle 10.
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            we = (i == 10); waddr = 5'd9; wdata = 32'hA5A5_A5A5;
            settle();
            chk($sformatf("clr_busy_%0d", i), 32'(init_busy), 32'd1);
            chk($sformatf("clr_rd_%0d", i), rdata1, 32'd0);
            chk($sformatf("clr_drop_%0d", i), 32'(wr_dropped), 32'(i == 11));
            tick();
        end
        we = 1'b0;
        settle();
        chk("run_busy", 32'(init_busy), 32'd0);
        chk("run_rd5", rdata1, 32'd0);
        chk("run_drop", 32'(wr_dropped), 32'd0);
        raddr1 = 5'd9;
        settle();
        chk("dropped_reg9", rdata1, 32'd0);

        // Write then read on both ports.
        tick();
        we = 1'b1; waddr = 5'd3; wdata = 32'h1234_5678;
        tick();
        we = 1'b0; re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd3;
        settle();
        chk("wr3_p1", rdata1, 32'h1234_5678);
        chk("wr3_p2", rdata2, 32'h1234_5678);

        // Forwarding on port 2 while port 1 reads the array.
        tick();
        we = 1'b1; waddr = 5'd7; wdata = 32'hDEAD_BEEF; raddr2 = 5'd7;
        settle();
        chk("fwd_p2", rdata2, 32'hDEAD_BEEF);
        chk("fwd_p1_other", rdata1, 32'h1234_5678);
        tick();
        we = 1'b0; raddr1 = 5'd7;
        settle();
        chk("reg7_p1", rdata1, 32'hDEAD_BEEF);
        chk("reg7_p2", rdata2, 32'hDEAD_BEEF);

        // Forwarding to both ports on the same address.
        tick();
        we = 1'b1; waddr = 5'd11; wdata = 32'hCAFE_0011; raddr1 = 5'd11; raddr2 = 5'd11;
        settle();
        chk("fwd2_p1", rdata1, 32'hCAFE_0011);
        chk("fwd2_p2", rdata2, 32'hCAFE_0011);

        // Register 0 ignores writes and never forwards.
        tick();
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; raddr1 = 5'd0; raddr2 = 5'd11;
        settle();
        chk("r0_fwd", rdata1, 32'd0);
        chk("r11_kept", rdata2, 32'hCAFE_0011);
        tick();
        we = 1'b0;
        settle();
        chk("r0_read", rdata1, 32'd0);
        chk("r0_nodrop", 32'(wr_dropped), 32'd0);

        // Read enables gate both the array and the forward path.
        re1 = 1'b0; raddr1 = 5'd3;
        settle();
        chk("re1_off", rdata1, 32'd0);
        we = 1'b1; waddr = 5'd3; wdata = 32'h1234_5678;
        settle();
        chk("re1_off_fwd", rdata1, 32'd0);
        re1 = 1'b1;
        settle();
        chk("re1_on_fwd", rdata1, 32'h1234_5678);

        // Mid-run reset wipes reg 4.
        tick();
        we = 1'b1; waddr = 5'd4; wdata = 32'h0000_00FF;
        tick();
        we = 1'b0; raddr1 = 5'd4;
        settle();
        chk("reg4", rdata1, 32'h0000_00FF);
        rst = 1'b1; we = 1'b1; waddr = 5'd4; wdata = 32'h5555_5555;
        settle();
        chk("mid_rst_busy", 32'(init_busy), 32'd1);
        chk("mid_rst_rd", rdata1, 32'd0);
        tick();
        rst = 1'b0; we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            settle();
            chk($sformatf("rclr_busy_%0d", i), 32'(init_busy), 32'd1);
            chk($sformatf("rclr_drop_%0d", i), 32'(wr_dropped), 32'd0);
            tick();
        end
        settle();
        chk("rrun_busy", 32'(init_busy), 32'd0);
        chk("rrun_reg4", rdata1, 32'd0);
        raddr1 = 5'd3; raddr2 = 5'd7;
        settle();
        chk("rrun_reg3", rdata1, 32'd0);
        chk("rrun_reg7", rdata2, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_resp.md
Name: regfile_resp

Overview:
- General-purpose register file that answers the decode stage's two read requests (enable + 5-bit address) and accepts one write-back per cycle.
- Sits beside the decode stage: decode issues the reads, this block returns the data in the same cycle, and write-back drives the write port.
- After every reset, an internal clear sequencer zeroes all registers, one per cycle, before normal operation resumes.
- Includes write-to-read forwarding so decode sees a value written in the same cycle.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width.
- NREGS, 32, number of registers; must equal 2**ADDR_W.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- we  in  1  write enable from write-back.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- re1  in  1  read-port-1 enable from decode.
- raddr1  in  ADDR_W  read-port-1 address.
- rdata1  out  DATA_W  read-port-1 data, combinational.
- re2  in  1  read-port-2 enable.
- raddr2  in  ADDR_W  read-port-2 address.
- rdata2  out  DATA_W  read-port-2 data, combinational.
- init_busy  out  1  high while rst is asserted or the clear sequence is running.
- wr_dropped  out  1  registered one-cycle pulse: a write with we=1 was discarded because init_busy was high.

Behaviour:
- Storage: NREGS x DATA_W flops. Register 0 is hardwired to 0; writes to it are discarded silently (no wr_dropped pulse).
- FSM has two states, CLEAR and RUN.
  - Any clock edge with rst=1: state <= CLEAR, clr_cnt <= 0, wr_dropped <= 0.
  - In CLEAR, each edge writes 0 to reg[clr_cnt] and increments clr_cnt.
  - On the edge where clr_cnt == NREGS-1, state <= RUN.
  - The sequence takes exactly NREGS cycles after rst deasserts.
- init_busy = rst OR (state == CLEAR), combinational.
- Write in RUN: on the edge where we=1 and waddr != 0, reg[waddr] <= wdata.
- Write while init_busy=1:
  - The write is ignored.
  - If we=1, wr_dropped = 1 on the following cycle, only when rst=0 at that edge.
- Read port k (k = 1, 2), priority order:
  1. rst=1 -> 0.
  2. init_busy=1 -> 0.
  3. rek=0 -> 0.
  4. raddrk=0 -> 0.
  5. we=1 and waddr == raddrk -> wdata (forwarding).
  6. otherwise -> reg[raddrk].
- Both ports are independent. Same address on both ports returns identical data, including the forwarded case.
- Reset values: rdata1 = rdata2 = 0, init_busy = 1, wr_dropped = 0; all registers read as 0 once the clear completes.
- Reset mid-CLEAR or mid-RUN: the clear sequence restarts at 0 and the full NREGS cycles are repeated. No partial state survives.
- No read latency: data is valid in the same cycle as the address. Writes become visible from the register array one cycle after the edge, and in the same cycle via forwarding.

Test Plan:
- Reset and clear: pulse rst for 2 cycles, then release. init_busy stays 1 for exactly 32 cycles after release, then 0. re1=1 with raddr1=5 reads 0 throughout and after.
- Write then read: in RUN, we=1, waddr=3, wdata=32'h1234_5678. Next cycle, re1=1/raddr1=3 and re2=1/raddr2=3 both return 32'h1234_5678.
- Forwarding: in the same cycle, we=1, waddr=7, wdata=32'hDEAD_BEEF, re2=1, raddr2=7. rdata2 = 32'hDEAD_BEEF in that cycle; reg[7] holds it afterwards.
- Register 0 and enables:
  - we=1, waddr=0, wdata=32'hFFFF_FFFF, then read raddr1=0 -> 0, with no wr_dropped pulse.
  - re1=0, raddr1=3 (holding 32'h1234_5678) -> rdata1 = 0.
- Dropped write: during CLEAR cycle 10, we=1, waddr=9, wdata=32'hA5A5_A5A5. wr_dropped pulses high for 1 cycle; after RUN is reached, raddr1=9 reads 0.
- Mid-operation reset: write 32'h0000_00FF to reg 4 in RUN, assert rst for 1 cycle. init_busy is high for 1 + 32 cycles; reg 4 then reads 0.
